// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM states,
// operand width and iteration count.
package mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mul_state_e;

   localparam int MUL_ITERS = 8;
   localparam int MUL_W     = 8;
   localparam int CNT_W     = 4;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITERS - 1);

endpackage

// File: rtl/fa_8.sv
// 8-bit adder with carry-in and carry-out, shared with the ALU datapath.
module fa_8 (
   input  logic [7:0] in1,
   input  logic [7:0] in2,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);

   assign {cout, sum} = {1'b0, in1} + {1'b0, in2} + {8'b0, cin};

endmodule

// File: rtl/mul_seq_8.sv
// Sequential 8x8 unsigned shift-add multiplier: one partial product per cycle
// through fa_8, 16-bit result after 8 iterations, start/busy/done handshake.
module mul_seq_8
   import mul_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [MUL_W-1:0]     multiplicand,
   input  logic [MUL_W-1:0]     multiplier,
   output logic [2*MUL_W-1:0]   product,
   output logic                 busy,
   output logic                 done
);

   mul_state_e        state_q, state_d;
   logic [MUL_W-1:0]  mcand_q, mcand_d;
   logic [MUL_W-1:0]  acc_hi_q, acc_hi_d;
   logic [MUL_W-1:0]  acc_lo_q, acc_lo_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [MUL_W-1:0]  fa_in2;
   logic [MUL_W-1:0]  fa_sum;
   logic              fa_cout;

   // Partial product: add the multiplicand only when the current multiplier bit is set.
   assign fa_in2 = acc_lo_q[0] ? mcand_q : '0;

   fa_8 u_fa (
      .in1  (acc_hi_q),
      .in2  (fa_in2),
      .cin  (1'b0),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      state_d  = state_q;
      mcand_d  = mcand_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      cnt_d    = cnt_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d  = multiplicand;
               acc_hi_d = '0;
               acc_lo_d = multiplier;
               cnt_d    = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            // The carry is the 9th bit of the partial sum and lands in acc_hi[7].
            {acc_hi_d, acc_lo_d} = {fa_cout, fa_sum, acc_lo_q[MUL_W-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         cnt_q    <= cnt_d;
      end
   end

   assign product = {acc_hi_q, acc_lo_q};
   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);

endmodule

// File: tb/tb_mul_seq_8.sv
// Self-checking bench for mul_seq_8: expected products come from plain
// multiplication, timing from the 9-cycle latency / 10-cycle throughput rules.
module tb_mul_seq_8;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  multiplicand;
   logic [7:0]  multiplier;
   logic [15:0] product;
   logic        busy;
   logic        done;

   int checks   = 0;
   int failures = 0;

   mul_seq_8 dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .product      (product),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
      return {8'h00, a} * {8'h00, b};
   endfunction

   // One full transaction from IDLE; checks latency, result, busy and the return to IDLE.
   task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input string tag);
      logic [15:0] exp_p;
      int          lat;
      exp_p = ref_mul(a, b);
      lat   = 0;
      @(negedge clk);
      start        = 1'b1;
      multiplicand = a;
      multiplier   = b;
      @(posedge clk);
      #1;
      start        = 1'b0;
      multiplicand = 8'($urandom);
      multiplier   = 8'($urandom);
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 1) begin
            checks++;
            if (busy !== 1'b1) begin
               failures++;
               $display("FAIL %s busy_after_accept: got %b want 1", tag, busy);
            end
         end
         if (done === 1'b1) begin
            lat = i;
            break;
         end
      end
      checks++;
      if (lat != 9) begin
         failures++;
         $display("FAIL %s latency: got %0d want 9 (0 = timeout)", tag, lat);
      end
      if (lat != 0) begin
         checks++;
         if (product !== exp_p) begin
            failures++;
            $display("FAIL %s product: got %h want %h", tag, product, exp_p);
         end
         checks++;
         if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_in_done: got %b want 1", tag, busy);
         end
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || product !== exp_p) begin
            failures++;
            $display("FAIL %s after_done: got done=%b busy=%b product=%h want 0 0 %h",
                     tag, done, busy, product, exp_p);
         end
      end
   endtask

   task automatic test_reset();
      reset        = 1'b1;
      start        = 1'b0;
      multiplicand = 8'h00;
      multiplier   = 8'h00;
      repeat (2) @(negedge clk);
      checks++;
      if (product !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: got product=%h busy=%b done=%b want 0000 0 0",
                  product, busy, done);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [7:0] ta [4] = '{8'h0F, 8'hFF, 8'h00, 8'hAB};
      logic [7:0] tb [4] = '{8'h0F, 8'hFF, 8'hAB, 8'h01};
      for (int i = 0; i < 4; i++) begin
         run_mul(ta[i], tb[i], $sformatf("directed%0d", i));
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 12; i++) begin
         run_mul(8'($urandom), 8'($urandom), $sformatf("random%0d", i));
      end
   endtask

   // start pulses during RUN and during DONE must be ignored and not queued.
   task automatic test_ignore_start();
      int          done_cnt;
      int          lat;
      logic [15:0] seen_p;
      done_cnt = 0;
      lat      = 0;
      seen_p   = 16'h0;
      @(negedge clk);
      start        = 1'b1;
      multiplicand = 8'h12;
      multiplier   = 8'h34;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (done === 1'b1) begin
            done_cnt++;
            lat    = i;
            seen_p = product;
            start  = 1'b1;
         end
         if (i == 3) begin
            start        = 1'b1;
            multiplicand = 8'hFF;
            multiplier   = 8'hFF;
         end
         if (i == 11) begin
            checks++;
            if (busy !== 1'b0) begin
               failures++;
               $display("FAIL ignore_start busy_after_done: got %b want 0", busy);
            end
         end
      end
      start = 1'b0;
      checks++;
      if (done_cnt != 1 || lat != 9) begin
         failures++;
         $display("FAIL ignore_start done_pulses: got count=%0d at=%0d want 1 at 9", done_cnt, lat);
      end
      checks++;
      if (seen_p !== 16'h03A8) begin
         failures++;
         $display("FAIL ignore_start product: got %h want 03a8", seen_p);
      end
   endtask

   task automatic test_reset_mid_run();
      int done_cnt;
      done_cnt = 0;
      @(negedge clk);
      start        = 1'b1;
      multiplicand = 8'($urandom_range(1, 255));
      multiplier   = 8'($urandom_range(1, 255));
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (product !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_run immediate: got product=%h busy=%b done=%b want 0000 0 0",
                  product, busy, done);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done === 1'b1) done_cnt++;
      end
      checks++;
      if (done_cnt != 0) begin
         failures++;
         $display("FAIL reset_mid_run stray_done: got %0d pulses want 0", done_cnt);
      end
      run_mul(8'h07, 8'h09, "after_reset");
   endtask

   // start held high: a new product every 10 cycles.
   task automatic test_back_to_back();
      int done_at [$];
      int bad_p;
      bad_p = 0;
      @(negedge clk);
      start        = 1'b1;
      multiplicand = 8'h10;
      multiplier   = 8'h10;
      @(posedge clk);
      #1;
      for (int i = 1; i <= 32; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            done_at.push_back(i);
            if (product !== 16'h0100) bad_p++;
         end
      end
      start = 1'b0;
      repeat (12) @(negedge clk);
      checks++;
      if (done_at.size() != 3) begin
         failures++;
         $display("FAIL back_to_back pulse_count: got %0d want 3", done_at.size());
      end else begin
         checks++;
         if (done_at[0] != 9 || done_at[1] != 19 || done_at[2] != 29) begin
            failures++;
            $display("FAIL back_to_back spacing: got %0d %0d %0d want 9 19 29",
                     done_at[0], done_at[1], done_at[2]);
         end
      end
      checks++;
      if (bad_p != 0) begin
         failures++;
         $display("FAIL back_to_back product: got %0d wrong results want 0100 every pulse", bad_p);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_ignore_start();
      test_reset_mid_run();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
